// File: rtl/imm_pack_if.sv
// imm_pack_if: request/response bundle for the instruction packer.
// Request side: in_valid/in_ready handshake with opcode, funct3, funct7, rd, rs1, rs2 and the immediate.
// Response side: out_valid/out_ready handshake with the packed instruction and its error flag.
// Status: err_cnt, the saturating count of accepted requests that could not be encoded.
interface imm_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_cnt;
    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_cnt
    );
    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_cnt
    );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: packs decoded fields and an immediate back into a 32-bit instruction through a 2-entry output FIFO.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset), bus (imm_pack_if.slave: request in, packed result out, err_cnt).
// in_ready depends only on the registered occupancy, so out_ready never reaches it combinationally.
module imm_pack (
    input logic       clk,
    input logic       rst,
    imm_pack_if.slave bus
);
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;

    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  occ;
    logic [32:0] e0;
    logic [32:0] e1;
    logic        push;
    logic        pop;

    assign imm = bus.in_imm;
    assign op  = bus.in_opcode;
    assign f3  = bus.in_funct3;

    always_comb begin
        instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, op};
        err   = 1'b0;
        case (op)
            AUIPC: begin
                instr = {imm[31:12], bus.in_rd, op};
                err   = imm[11:0] != 12'd0;
            end
            JAL: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
                err   = imm[0] || imm[31:21] != {11{imm[20]}};
            end
            JALR: begin
                instr = {imm[11:0], bus.in_rs1, f3, bus.in_rd, op};
                err   = imm[31:12] != {20{imm[11]}};
            end
            BRANCH: begin
                instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11], op};
                err   = imm[0] || imm[31:13] != {19{imm[12]}};
            end
            // loads and stores carry a word offset: the two low bits must be zero
            STORE: begin
                instr = {imm[13:7], bus.in_rs2, bus.in_rs1, f3, imm[6:2], op};
                err   = imm[1:0] != 2'd0 || imm[31:14] != {18{imm[13]}};
            end
            LOAD: begin
                instr = {imm[13:2], bus.in_rs1, f3, bus.in_rd, op};
                err   = imm[1:0] != 2'd0 || imm[31:14] != {18{imm[13]}};
            end
            // shifts keep funct7 in the upper bits and an unsigned 5-bit shamt
            OPIMM: begin
                instr = (f3[0] && !f3[1]) ? {bus.in_funct7, imm[4:0], bus.in_rs1, f3, bus.in_rd, op}
                                          : {imm[11:0], bus.in_rs1, f3, bus.in_rd, op};
                err   = (f3[0] && !f3[1]) ? imm[31:5] != 27'd0 : imm[31:12] != {20{imm[11]}};
            end
            default: begin
                instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, op};
                err   = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = occ != 2'd2;
    assign bus.out_valid = occ != 2'd0;
    assign bus.out_instr = e0[32:1];
    assign bus.out_err   = e0[0];
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // e0 is always the head; e1 only holds the second entry when two are buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            occ         <= 2'd0;
            e0          <= '0;
            e1          <= '0;
            bus.err_cnt <= 8'd0;
        end else begin
            occ <= occ + 2'(push) - 2'(pop);
            if (pop && occ == 2'd2)
                e0 <= e1;
            else if (push && (occ == 2'd0 || pop))
                e0 <= {instr, err};
            if (push && occ == 2'd1 && !pop)
                e1 <= {instr, err};
            if (push && err && bus.err_cnt != 8'hff)
                bus.err_cnt <= bus.err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: randomized and directed self-checking bench for imm_pack against a queue-based reference model.
module tb_imm_pack;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [6:0]  op;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    item_t q[$];
    int cnt = 0;
    logic acc;

    logic        n_rst = 1'b0;
    logic        n_valid = 1'b0;
    logic        n_ready = 1'b1;
    logic [6:0]  n_op = '0;
    logic [2:0]  n_f3 = '0;
    logic [6:0]  n_f7 = '0;
    logic [4:0]  n_rd = '0;
    logic [4:0]  n_rs1 = '0;
    logic [4:0]  n_rs2 = '0;
    logic [31:0] n_imm = '0;

    imm_pack_if bus();
    imm_pack dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_shift(input logic [2:0] f3);
        return f3 == 3'd1 || f3 == 3'd5;
    endfunction

    function automatic logic has_imm(input logic [6:0] op);
        return op inside {AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM};
    endfunction

    // encodability judged from the numeric range and alignment of the immediate
    function automatic logic exp_err(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (op)
            AUIPC:        return (imm & 32'hfff) != 0;
            JAL:          return (s % 2 != 0) || s < -1048576 || s >= 1048576;
            JALR:         return s < -2048 || s > 2047;
            BRANCH:       return (s % 2 != 0) || s < -4096 || s > 4095;
            LOAD, STORE:  return (s % 4 != 0) || s < -8192 || s > 8191;
            OPIMM:        return is_shift(f3) ? imm > 31 : (s < -2048 || s > 2047);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
        case (op)
            AUIPC:  return {imm[31:12], rd, op};
            JAL:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            JALR:   return {imm[11:0], rs1, f3, rd, op};
            BRANCH: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            STORE:  return {imm[13:7], rs2, rs1, f3, imm[6:2], op};
            LOAD:   return {imm[13:2], rs1, f3, rd, op};
            OPIMM:  return is_shift(f3) ? {f7, imm[4:0], rs1, f3, rd, op} : {imm[11:0], rs1, f3, rd, op};
            default: return {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    // the core's immediate extractor (word-scaled loads/stores)
    function automatic logic [31:0] ext(input logic [31:0] i);
        case (i[6:0])
            AUIPC:  return {i[31:12], 12'b0};
            JAL:    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            JALR:   return {{20{i[31]}}, i[31:20]};
            BRANCH: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            STORE:  return {{18{i[31]}}, i[31:25], i[11:7], 2'b0};
            LOAD:   return {{18{i[31]}}, i[31:20], 2'b0};
            OPIMM:  return is_shift(i[14:12]) ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
            default: return 32'd0;
        endcase
    endfunction

    // one cycle: check registered outputs at negedge, then drive the next inputs and account the handshakes they cause
    task automatic tick();
        item_t it;
        acc = 1'b0;
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("err_cnt", 32'(bus.err_cnt), cnt);
        if (q.size() > 0) begin
            chk("out_instr", bus.out_instr, q[0].instr);
            chk("out_err", 32'(bus.out_err), 32'(q[0].err));
        end
        rst = n_rst;
        bus.in_valid = n_valid;
        bus.in_opcode = n_op;
        bus.in_funct3 = n_f3;
        bus.in_funct7 = n_f7;
        bus.in_rd = n_rd;
        bus.in_rs1 = n_rs1;
        bus.in_rs2 = n_rs2;
        bus.in_imm = n_imm;
        bus.out_ready = n_ready;
        if (n_rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (bus.out_valid && n_ready && q.size() > 0) begin
                if (!q[0].err && has_imm(q[0].op))
                    chk("roundtrip", ext(bus.out_instr), q[0].imm);
                void'(q.pop_front());
            end
            if (n_valid && bus.in_ready) begin
                it.instr = enc(n_op, n_f3, n_f7, n_rd, n_rs1, n_rs2, n_imm);
                it.err = exp_err(n_op, n_f3, n_imm);
                it.imm = n_imm;
                it.op = n_op;
                q.push_back(it);
                if (it.err && cnt < 255) cnt++;
                acc = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        n_valid = 1'b1;
        n_op = op; n_f3 = f3; n_f7 = f7; n_rd = rd; n_rs1 = rs1; n_rs2 = rs2; n_imm = imm;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        n_valid = 1'b0;
    endtask

    task automatic rand_fields();
        int k;
        n_f3 = 3'($urandom); n_f7 = 7'($urandom);
        n_rd = 5'($urandom); n_rs1 = 5'($urandom); n_rs2 = 5'($urandom);
        case ($urandom_range(0, 9))
            0: n_op = LUI;    1: n_op = AUIPC;  2: n_op = JAL;
            3: n_op = JALR;   4: n_op = BRANCH; 5: n_op = LOAD;
            6: n_op = STORE;  7: n_op = OPIMM;  8: n_op = OP;
            default: n_op = 7'($urandom);
        endcase
        k = $urandom_range(0, 4);
        n_imm = k == 0 ? $urandom :
                k == 1 ? 32'($urandom_range(0, 32767)) - 32'd16384 :
                k == 2 ? (32'($urandom_range(0, 8191)) - 32'd4096) << 2 :
                k == 3 ? 32'($urandom_range(0, 40)) : ($urandom & 32'hfffff000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);

        n_ready = 1'b1;
        send(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
        tick();
        chk("jal_valid", 32'(bus.out_valid), 32'd1);
        chk("jal_instr", bus.out_instr, 32'h001000EF);
        chk("jal_err", 32'(bus.out_err), 32'd0);

        send(LOAD, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 32'h00000006);
        tick();
        chk("load_err", 32'(bus.out_err), 32'd1);
        chk("load_errcnt", 32'(bus.err_cnt), 32'd1);
        send(LOAD, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 32'h00000008);
        tick();
        chk("load_instr", bus.out_instr, 32'h00212283);
        chk("load_ok", 32'(bus.out_err), 32'd0);

        send(OPIMM, 3'd1, 7'd0, 5'd3, 5'd3, 5'd0, 32'd31);
        tick();
        chk("slli_instr", bus.out_instr, 32'h01F19193);
        chk("slli_err", 32'(bus.out_err), 32'd0);
        send(OPIMM, 3'd1, 7'd0, 5'd3, 5'd3, 5'd0, 32'd32);
        tick();
        chk("slli32_err", 32'(bus.out_err), 32'd1);

        n_ready = 1'b0;
        send(OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        send(OP, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
        n_valid = 1'b1; n_rd = 5'd7; n_rs1 = 5'd8; n_rs2 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_head", bus.out_instr, enc(OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0));
        end
        n_ready = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) tick();
        chk("bp_third_accepted", 32'(acc), 32'd1);
        n_valid = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 260; i++) send(LOAD, 3'd2, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        tick();
        chk("sat_errcnt", 32'(bus.err_cnt), 32'd255);

        n_ready = 1'b0;
        send(JALR, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4);
        send(JALR, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd8);
        n_valid = 1'b1;
        tick();
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0; n_valid = 1'b0;
        tick();
        chk("rst2_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_ready", 32'(bus.in_ready), 32'd1);
        chk("rst2_errcnt", 32'(bus.err_cnt), 32'd0);
        chk("rst2_instr", bus.out_instr, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            n_ready = $urandom_range(0, 3) != 0;
            n_valid = $urandom_range(0, 2) != 0;
            rand_fields();
            tick();
        end
        n_valid = 1'b0; n_ready = 1'b1;
        repeat (4) tick();
        chk("drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
